// File: rtl/regfile_wb_arbiter.sv
// Register file write-port arbiter between the in-order WB stage and the multi-cycle unit,
// with starvation-driven pipeline stall and a busy scoreboard for decode RAW detection.
module regfile_wb_arbiter #(
  parameter int unsigned REG_WIDTH    = 32,
  parameter int unsigned FILE_DEPTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  localparam int unsigned ADDR_WIDTH  = $clog2(FILE_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_wb_valid,
  input  logic [ADDR_WIDTH-1:0] i_wb_addr,
  input  logic [REG_WIDTH-1:0]  i_wb_data,
  input  logic                  i_mc_valid,
  input  logic [ADDR_WIDTH-1:0] i_mc_addr,
  input  logic [REG_WIDTH-1:0]  i_mc_data,
  output logic                  o_mc_ready,
  output logic                  o_pipe_stall,
  input  logic                  i_issue_valid,
  input  logic [ADDR_WIDTH-1:0] i_issue_addr,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr_a,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr_b,
  output logic                  o_busy_a,
  output logic                  o_busy_b,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [REG_WIDTH-1:0]  o_wr_data
);

  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

  typedef enum logic [0:0] {StNormal, StStall} state_e;

  state_e                state_q;
  logic [3:0]            starve_cnt_q;
  logic [3:0]            starve_cnt_inc;
  logic [FILE_DEPTH-1:0] busy_q, busy_d;
  logic                  wb_grant;
  logic                  mc_grant;

  // Grant decode: WB has priority in NORMAL, the multi-cycle unit owns the port in STALL.
  always_comb begin
    wb_grant = 1'b0;
    mc_grant = 1'b0;
    if (state_q == StStall) begin
      mc_grant = i_mc_valid;
    end else if (i_wb_valid) begin
      wb_grant = 1'b1;
    end else begin
      mc_grant = i_mc_valid;
    end
  end

  assign starve_cnt_inc = (starve_cnt_q == StarveMax) ? starve_cnt_q : starve_cnt_q + 4'd1;

  // Outputs are forced low while reset is held so a pending grant never reaches the file.
  always_comb begin
    o_wr_en      = (wb_grant | mc_grant) & i_reset_n;
    o_mc_ready   = mc_grant & i_reset_n;
    o_pipe_stall = (state_q == StStall) & i_reset_n;
    o_wr_addr    = wb_grant ? i_wb_addr : i_mc_addr;
    o_wr_data    = wb_grant ? i_wb_data : i_mc_data;
    o_busy_a     = busy_q[i_rd_addr_a] & i_reset_n;
    o_busy_b     = busy_q[i_rd_addr_b] & i_reset_n;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= StNormal;
      starve_cnt_q <= 4'd0;
    end else begin
      unique case (state_q)
        StNormal: begin
          if (i_wb_valid && i_mc_valid) begin
            starve_cnt_q <= starve_cnt_inc;
            if (starve_cnt_inc == StarveMax) begin
              state_q <= StStall;
            end
          end else begin
            starve_cnt_q <= 4'd0;
          end
        end
        StStall: begin
          state_q      <= StNormal;
          starve_cnt_q <= 4'd0;
        end
        default: begin
          state_q      <= StNormal;
          starve_cnt_q <= 4'd0;
        end
      endcase
    end
  end

  // Scoreboard: a new issue overrides a same-cycle retire of the same register.
  always_comb begin
    busy_d = busy_q;
    if (mc_grant) begin
      busy_d[i_mc_addr] = 1'b0;
    end
    if (i_issue_valid && (i_issue_addr != '0)) begin
      busy_d[i_issue_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter with hand-computed expectations.
module tb_regfile_wb_arbiter;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_wb_valid, i_mc_valid, i_issue_valid;
  logic [4:0]  i_wb_addr, i_mc_addr, i_issue_addr, i_rd_addr_a, i_rd_addr_b;
  logic [31:0] i_wb_data, i_mc_data;
  logic        o_mc_ready, o_pipe_stall, o_busy_a, o_busy_b, o_wr_en;
  logic [4:0]  o_wr_addr;
  logic [31:0] o_wr_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 i_clk = ~i_clk;

  regfile_wb_arbiter #(
    .REG_WIDTH   (32),
    .FILE_DEPTH  (32),
    .STARVE_LIMIT(4)
  ) u_dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_wb_valid   (i_wb_valid),
    .i_wb_addr    (i_wb_addr),
    .i_wb_data    (i_wb_data),
    .i_mc_valid   (i_mc_valid),
    .i_mc_addr    (i_mc_addr),
    .i_mc_data    (i_mc_data),
    .o_mc_ready   (o_mc_ready),
    .o_pipe_stall (o_pipe_stall),
    .i_issue_valid(i_issue_valid),
    .i_issue_addr (i_issue_addr),
    .i_rd_addr_a  (i_rd_addr_a),
    .i_rd_addr_b  (i_rd_addr_b),
    .o_busy_a     (o_busy_a),
    .o_busy_b     (o_busy_b),
    .o_wr_en      (o_wr_en),
    .o_wr_addr    (o_wr_addr),
    .o_wr_data    (o_wr_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled 2ns later.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    i_reset_n     = 1'b0;
    i_wb_valid    = 1'b1;
    i_wb_addr     = 5'd1;
    i_wb_data     = 32'h1;
    i_mc_valid    = 1'b1;
    i_mc_addr     = 5'd2;
    i_mc_data     = 32'h2;
    i_issue_valid = 1'b0;
    i_issue_addr  = 5'd0;
    i_rd_addr_a   = 5'd0;
    i_rd_addr_b   = 5'd0;

    // Reset holds every output low even with both requesters valid.
    settle();
    check("rst_wr_en", o_wr_en, 0);
    check("rst_mc_ready", o_mc_ready, 0);
    check("rst_stall", o_pipe_stall, 0);
    check("rst_busy_a", o_busy_a, 0);
    step();
    i_wb_valid = 1'b0;
    i_mc_valid = 1'b0;
    step();
    i_reset_n = 1'b1;
    step();

    // Plain WB write.
    i_wb_valid = 1'b1;
    i_wb_addr  = 5'd5;
    i_wb_data  = 32'h1234;
    settle();
    check("wb_wr_en", o_wr_en, 1);
    check("wb_wr_addr", o_wr_addr, 5);
    check("wb_wr_data", o_wr_data, 32'h1234);
    check("wb_mc_ready", o_mc_ready, 0);
    step();
    i_wb_valid = 1'b0;
    settle();
    check("idle_wr_en", o_wr_en, 0);

    // Issue to x7, then retire it from the multi-cycle unit.
    i_issue_valid = 1'b1;
    i_issue_addr  = 5'd7;
    i_rd_addr_a   = 5'd7;
    settle();
    check("x7_busy_same_cycle", o_busy_a, 0);
    step();
    i_issue_valid = 1'b0;
    settle();
    check("x7_busy_set", o_busy_a, 1);
    step();
    i_mc_valid = 1'b1;
    i_mc_addr  = 5'd7;
    i_mc_data  = 32'hBEEF;
    settle();
    check("x7_mc_ready", o_mc_ready, 1);
    check("x7_wr_en", o_wr_en, 1);
    check("x7_wr_addr", o_wr_addr, 7);
    check("x7_wr_data", o_wr_data, 32'hBEEF);
    check("x7_busy_not_bypassed", o_busy_a, 1);
    step();
    i_mc_valid = 1'b0;
    settle();
    check("x7_busy_cleared", o_busy_a, 0);
    step();

    // Starvation: WB held for 10 cycles against a valid MC request.
    i_wb_valid = 1'b1;
    i_wb_addr  = 5'd1;
    i_mc_valid = 1'b1;
    i_mc_addr  = 5'd10;
    i_mc_data  = 32'hAAAA;
    for (int c = 0; c < 10; c++) begin
      i_wb_data = 32'(c);
      settle();
      check($sformatf("starve_stall_c%0d", c), o_pipe_stall, (c == 4 || c == 9));
      check($sformatf("starve_ready_c%0d", c), o_mc_ready, (c == 4 || c == 9));
      check($sformatf("starve_addr_c%0d", c), o_wr_addr, (c == 4 || c == 9) ? 10 : 1);
      check($sformatf("starve_wr_en_c%0d", c), o_wr_en, 1);
      step();
    end
    i_wb_valid = 1'b0;
    i_mc_valid = 1'b0;
    step();

    // Same-cycle issue and retire on x9: issue wins.
    i_issue_valid = 1'b1;
    i_issue_addr  = 5'd9;
    step();
    i_mc_valid = 1'b1;
    i_mc_addr  = 5'd9;
    i_mc_data  = 32'h99;
    settle();
    check("x9_mc_ready", o_mc_ready, 1);
    step();
    i_issue_valid = 1'b0;
    i_mc_valid    = 1'b0;
    i_rd_addr_b   = 5'd9;
    settle();
    check("x9_busy_kept", o_busy_b, 1);
    // Issue to x0 never sets busy.
    i_issue_valid = 1'b1;
    i_issue_addr  = 5'd0;
    step();
    i_issue_valid = 1'b0;
    i_rd_addr_a   = 5'd0;
    settle();
    check("x0_busy", o_busy_a, 0);
    step();

    // Reset during STALL drops every output at once.
    i_wb_valid = 1'b1;
    i_wb_addr  = 5'd1;
    i_mc_valid = 1'b1;
    i_mc_addr  = 5'd12;
    for (int c = 0; c < 4; c++) begin
      settle();
      check($sformatf("pre_rst_stall_c%0d", c), o_pipe_stall, 0);
      step();
    end
    settle();
    check("in_stall", o_pipe_stall, 1);
    i_reset_n = 1'b0;
    #1;
    check("rst_in_stall_stall", o_pipe_stall, 0);
    check("rst_in_stall_wr_en", o_wr_en, 0);
    check("rst_in_stall_ready", o_mc_ready, 0);
    check("rst_in_stall_busy_b", o_busy_b, 0);
    step();
    i_reset_n = 1'b1;
    settle();
    check("post_rst_busy_b", o_busy_b, 0);

    // Reset with the counter at 2 forces a fresh 4-cycle count.
    for (int c = 0; c < 2; c++) begin
      settle();
      check($sformatf("cnt2_stall_c%0d", c), o_pipe_stall, 0);
      check($sformatf("cnt2_addr_c%0d", c), o_wr_addr, 1);
      step();
    end
    i_reset_n = 1'b0;
    #1;
    check("rst_cnt2_wr_en", o_wr_en, 0);
    step();
    i_reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      settle();
      check($sformatf("fresh_stall_c%0d", c), o_pipe_stall, (c == 4));
      check($sformatf("fresh_ready_c%0d", c), o_mc_ready, (c == 4));
      step();
    end
    i_wb_valid = 1'b0;
    i_mc_valid = 1'b0;
    step();

    // Both valid on x3: WB data first, MC data on the next WB-idle cycle.
    i_wb_valid = 1'b1;
    i_wb_addr  = 5'd3;
    i_wb_data  = 32'h3333;
    i_mc_valid = 1'b1;
    i_mc_addr  = 5'd3;
    i_mc_data  = 32'h4444;
    settle();
    check("x3_wb_data", o_wr_data, 32'h3333);
    check("x3_wb_ready", o_mc_ready, 0);
    step();
    i_wb_valid = 1'b0;
    settle();
    check("x3_mc_data", o_wr_data, 32'h4444);
    check("x3_mc_addr", o_wr_addr, 3);
    check("x3_mc_ready", o_mc_ready, 1);
    step();
    i_mc_valid = 1'b0;
    settle();
    check("final_idle_wr_en", o_wr_en, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
